ring_rx_deframer: RTL and testbench
===================================

Name: ring_rx_deframer

Overview:
Receive stage directly upstream of the core control FSM. It synchronizes the serial ring input and deframes one packet at a time. It decodes type, address and payload, checks parity and framing, and presents the result to the control FSM. Delivery uses a hold-until-consumed handshake: rx_has_data, data_type, address, bad_decode out; rc_ready in.

Parameters:
DATA_WIDTH, 8, payload bits per frame
FRAME_BITS, DATA_WIDTH+8, bits shifted in SHIFT state (3 type + 4 address + DATA_WIDTH payload + 1 parity)

Ports:
Clk_R  input  1  clock
Rst_n  input  1  asynchronous active-low reset
Rx_In  input  1  serial ring line, idle high, asynchronous to Clk_R
rc_ready  input  1  control FSM can accept a packet this cycle
rx_has_data  output  1  packet held on outputs and not yet consumed
data_type  output  3  packet type: TOKEN=111, ACK=000, NACK=011, DATA_C=010, DATA_3=001
address  output  4  destination address field
payload  output  DATA_WIDTH  payload field
bad_decode  output  1  held packet has a parity, framing or type error
rx_overrun  output  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Interface: one clock (Clk_R); reset asynchronous, active-low (Rst_n).
- Reset values:
  - rx_has_data, data_type, address, payload, bad_decode and rx_overrun are all 0.
  - Both synchronizer flops are 1 (line idle).
  - The FSM is in IDLE and the bit counter is 0.
- Synchronizer: Rx_In passes through 2 flops. "rxs" below means the second flop output. All sampling uses rxs, one bit per clock.
- Frame on the line, in order:
  - start bit 0
  - type[2:0], MSB first
  - address[3:0], MSB first
  - payload, MSB first
  - parity bit: even parity over type, address and payload
  - stop bit 1
- FSM states:
  - IDLE: when rxs=0 (start bit), go to SHIFT and clear the counter. Otherwise stay.
  - SHIFT: shift rxs into the shift register LSB-in every cycle and increment the counter. When the counter reaches FRAME_BITS-1, go to STOP.
  - STOP: sample the stop bit and complete the frame (see below).
    - stop=1: go to IDLE. A start bit may begin on the very next cycle (back-to-back frames allowed).
    - stop=0: go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. A held-low line is never taken as a new start bit.
- bad_decode is set for the packet if any of these holds:
  - parity mismatch
  - stop bit 0
  - type in {100,101,110}
- A bad packet is still delivered, with all fields as received.
- Frame completion is the cycle in STOP:
  - If rx_has_data=0, or (rx_has_data=1 and rc_ready=1): load all output fields and set rx_has_data=1 on the next edge. A consume and a new completion in the same cycle therefore hold rx_has_data high with the new fields.
  - If rx_has_data=1 and rc_ready=0: drop the new frame, keep the old fields, and pulse rx_overrun for 1 cycle.
- Consume: rx_has_data=1 and rc_ready=1 with no completion in that cycle. rx_has_data goes to 0 on the next edge; the field outputs keep their values.
- Output fields change only on a load, and are stable while rx_has_data=1.
- Latency: rx_has_data rises 1 edge after rxs shows the stop bit, i.e. 3 edges after Rx_In carries the stop bit.
- Reset mid-frame: all state is cleared immediately. The partially received frame is discarded, with no overrun pulse and no bad_decode.

Test Plan:
- Clean DATA_C frame: type=010, addr=0001, payload=0xA5, even parity, stop=1, rc_ready=0. Required: rx_has_data=1 exactly 3 edges after the stop bit on Rx_In; fields read 010/0001/0xA5 with bad_decode=0; all outputs hold until rc_ready=1, then rx_has_data=0 on the next edge.
- Parity error: TOKEN frame, type=111, addr=0000, payload=0x00, parity bit forced to 0. Required: rx_has_data=1, bad_decode=1, data_type=111.
- Framing error: ACK frame with stop=0, then the line held low 20 cycles, then released high. Required: bad_decode=1; FSM stays in BREAK with no second frame; the next valid frame after release is received correctly.
- Back-to-back frames with no idle bits, 0x11 then 0x22, rc_ready=0 throughout. Required: first packet held with payload=0x11; rx_overrun pulses 1 cycle at the second completion; payload stays 0x11.
- Same back-to-back pair with rc_ready=1 in the STOP cycle of the second frame. Required: rx_has_data stays 1, payload becomes 0x22, no rx_overrun.
- Rst_n asserted at bit 6 of a frame. Required: all outputs 0 asynchronously; after release, a new frame with payload=0x3C is received correctly.

Source files
------------

// File: rtl/ring_rx_deframer.sv
// Serial ring receiver: 2-flop synchronizer, start/stop deframer, parity/type check,
// and a hold-until-consumed output register toward the control FSM.
module ring_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_BITS = DATA_WIDTH + 8
) (
  input  logic                  Clk_R,
  input  logic                  Rst_n,
  input  logic                  Rx_In,
  input  logic                  rc_ready,
  output logic                  rx_has_data,
  output logic [2:0]            data_type,
  output logic [3:0]            address,
  output logic [DATA_WIDTH-1:0] payload,
  output logic                  bad_decode,
  output logic                  rx_overrun
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  logic                  rx_meta_q;
  logic                  rxs_q;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;

  logic                  has_q, has_d;
  logic [2:0]            type_q, type_d;
  logic [3:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pay_q, pay_d;
  logic                  bad_q, bad_d;
  logic                  ovr_q, ovr_d;

  logic                  frame_done;
  logic [2:0]            rx_type;
  logic [3:0]            rx_addr;
  logic [DATA_WIDTH-1:0] rx_pay;
  logic                  parity_err;
  logic                  type_err;
  logic                  frame_bad;

  // Line is idle-high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= Rx_In;
      rxs_q     <= rx_meta_q;
    end
  end

  // Shift register is filled LSB-in, so the first received bit ends up at the top.
  assign rx_type    = shift_q[FRAME_BITS-1 -: 3];
  assign rx_addr    = shift_q[FRAME_BITS-4 -: 4];
  assign rx_pay     = shift_q[DATA_WIDTH:1];
  assign parity_err = ^shift_q;
  assign type_err   = (rx_type == 3'b100) || (rx_type == 3'b101) || (rx_type == 3'b110);
  assign frame_bad  = parity_err || type_err || !rxs_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        shift_d = {shift_q[FRAME_BITS-2:0], rxs_q};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        frame_done = 1'b1;
        state_d    = rxs_q ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        // A held-low line after a framing error must not look like a start bit.
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    has_d  = has_q;
    type_d = type_q;
    addr_d = addr_q;
    pay_d  = pay_q;
    bad_d  = bad_q;
    ovr_d  = 1'b0;
    if (frame_done) begin
      if (!has_q || rc_ready) begin
        has_d  = 1'b1;
        type_d = rx_type;
        addr_d = rx_addr;
        pay_d  = rx_pay;
        bad_d  = frame_bad;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (has_q && rc_ready) begin
      has_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      has_q   <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      pay_q   <= '0;
      bad_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      has_q   <= has_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      pay_q   <= pay_d;
      bad_q   <= bad_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_has_data = has_q;
  assign data_type   = type_q;
  assign address     = addr_q;
  assign payload     = pay_q;
  assign bad_decode  = bad_q;
  assign rx_overrun  = ovr_q;

endmodule

// File: tb/tb_ring_rx_deframer.sv
// Directed plus randomized frames against a packet-level model of the ring receiver.
module tb_ring_rx_deframer;

  localparam int DW = 8;
  localparam int FB = DW + 8;

  logic          Clk_R = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Rx_In = 1'b1;
  logic          rc_ready = 1'b0;
  logic          rx_has_data;
  logic [2:0]    data_type;
  logic [3:0]    address;
  logic [DW-1:0] payload;
  logic          bad_decode;
  logic          rx_overrun;

  int total = 0;
  int bad = 0;

  // Expected packet held on the outputs, and expected overrun at the last completion.
  logic          exp_has = 1'b0;
  logic [2:0]    exp_t = '0;
  logic [3:0]    exp_a = '0;
  logic [DW-1:0] exp_p = '0;
  logic          exp_b = 1'b0;
  logic          exp_ovr = 1'b0;

  ring_rx_deframer #(.DATA_WIDTH(DW)) dut (
    .Clk_R       (Clk_R),
    .Rst_n       (Rst_n),
    .Rx_In       (Rx_In),
    .rc_ready    (rc_ready),
    .rx_has_data (rx_has_data),
    .data_type   (data_type),
    .address     (address),
    .payload     (payload),
    .bad_decode  (bad_decode),
    .rx_overrun  (rx_overrun)
  );

  always #5 Clk_R = ~Clk_R;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".has"}, 32'(rx_has_data), 32'(exp_has));
    chk({tag, ".type"}, 32'(data_type), 32'(exp_t));
    chk({tag, ".addr"}, 32'(address), 32'(exp_a));
    chk({tag, ".payload"}, 32'(payload), 32'(exp_p));
    chk({tag, ".bad"}, 32'(bad_decode), 32'(exp_b));
    chk({tag, ".overrun"}, 32'(rx_overrun), 32'(exp_ovr));
  endtask

  function automatic logic even_par(input logic [2:0] t, input logic [3:0] a, input logic [DW-1:0] p);
    return ^{t, a, p};
  endfunction

  // Packet-level rules: what a completed frame does to the held packet.
  task automatic model_complete(input logic [2:0] t, input logic [3:0] a, input logic [DW-1:0] p,
                                input logic par, input logic stop, input logic ready);
    if (!exp_has || ready) begin
      exp_has = 1'b1;
      exp_t   = t;
      exp_a   = a;
      exp_p   = p;
      exp_b   = (par != even_par(t, a, p)) || !stop || (t == 3'd4) || (t == 3'd5) || (t == 3'd6);
      exp_ovr = 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge Clk_R);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] t, input logic [3:0] a, input logic [DW-1:0] p,
                            input logic par, input logic stop, input int nbits);
    logic [FB+1:0] f;
    f = {1'b0, t, a, p, par, stop};
    for (int i = FB + 1; i > FB + 1 - nbits; i--) begin
      Rx_In = f[i];
      tick();
    end
  endtask

  task automatic consume(input string tag);
    rc_ready = 1'b1;
    tick();
    rc_ready = 1'b0;
    exp_has = 1'b0;
    exp_ovr = 1'b0;
    chk_model(tag);
  endtask

  task automatic idle(input int n);
    Rx_In = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [2:0]    t;
    logic [3:0]    a;
    logic [DW-1:0] p;
    logic          par;
    logic          stop;
    int            n;

    // Reset state
    #3;
    chk_model("reset");
    tick();
    Rst_n = 1'b1;
    idle(3);
    chk_model("post_reset");

    // Clean DATA_C frame, exact latency and hold-until-consumed
    send_frame(3'b010, 4'b0001, 8'hA5, even_par(3'b010, 4'b0001, 8'hA5), 1'b1, FB + 2);
    tick();
    chk("datac.edge2_has", 32'(rx_has_data), 32'd0);
    tick();
    model_complete(3'b010, 4'b0001, 8'hA5, even_par(3'b010, 4'b0001, 8'hA5), 1'b1, 1'b0);
    chk_model("datac.edge3");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_model("datac.hold");
    end
    consume("datac.consume");

    // Parity error on a TOKEN frame
    idle(2);
    send_frame(3'b111, 4'b0000, 8'h00, 1'b0, 1'b1, FB + 2);
    tick();
    tick();
    model_complete(3'b111, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0);
    chk_model("parity");
    chk("parity.bad_set", 32'(bad_decode), 32'd1);
    consume("parity.consume");

    // Framing error, line held low, then a good frame after release
    idle(2);
    send_frame(3'b000, 4'b0101, 8'h5A, even_par(3'b000, 4'b0101, 8'h5A), 1'b0, FB + 2);
    tick();
    tick();
    model_complete(3'b000, 4'b0101, 8'h5A, even_par(3'b000, 4'b0101, 8'h5A), 1'b0, 1'b0);
    chk_model("framing");
    consume("framing.consume");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("break.no_frame", 32'({rx_has_data, rx_overrun}), 32'd0);
    end
    idle(2);
    send_frame(3'b001, 4'b1001, 8'hC3, even_par(3'b001, 4'b1001, 8'hC3), 1'b1, FB + 2);
    tick();
    tick();
    model_complete(3'b001, 4'b1001, 8'hC3, even_par(3'b001, 4'b1001, 8'hC3), 1'b1, 1'b0);
    chk_model("after_break");
    consume("after_break.consume");

    // Back-to-back, rc_ready low throughout: second frame overruns
    idle(2);
    send_frame(3'b010, 4'b0001, 8'h11, even_par(3'b010, 4'b0001, 8'h11), 1'b1, FB + 2);
    send_frame(3'b010, 4'b0001, 8'h22, even_par(3'b010, 4'b0001, 8'h22), 1'b1, FB + 2);
    model_complete(3'b010, 4'b0001, 8'h11, even_par(3'b010, 4'b0001, 8'h11), 1'b1, 1'b0);
    tick();
    chk("b2b.pre_overrun", 32'(rx_overrun), 32'd0);
    tick();
    model_complete(3'b010, 4'b0001, 8'h22, even_par(3'b010, 4'b0001, 8'h22), 1'b1, 1'b0);
    chk_model("b2b.overrun");
    tick();
    exp_ovr = 1'b0;
    chk_model("b2b.pulse_end");
    consume("b2b.consume");

    // Back-to-back with consume in the second frame's completion cycle
    idle(2);
    send_frame(3'b010, 4'b0001, 8'h11, even_par(3'b010, 4'b0001, 8'h11), 1'b1, FB + 2);
    send_frame(3'b010, 4'b0001, 8'h22, even_par(3'b010, 4'b0001, 8'h22), 1'b1, FB + 2);
    model_complete(3'b010, 4'b0001, 8'h11, even_par(3'b010, 4'b0001, 8'h11), 1'b1, 1'b0);
    tick();
    chk_model("b2b_rdy.first_held");
    rc_ready = 1'b1;
    tick();
    rc_ready = 1'b0;
    model_complete(3'b010, 4'b0001, 8'h22, even_par(3'b010, 4'b0001, 8'h22), 1'b1, 1'b1);
    chk_model("b2b_rdy.replace");
    tick();
    chk_model("b2b_rdy.still_held");

    // Randomized frames: random fields, parity/stop corruption, random consumes
    for (int k = 0; k < 40; k++) begin
      if (exp_has && ($urandom_range(0, 1) == 1)) consume("rand.consume");
      t    = 3'($urandom_range(0, 7));
      a    = 4'($urandom_range(0, 15));
      p    = DW'($urandom_range(0, 255));
      par  = even_par(t, a, p) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(t, a, p, par, stop, FB + 2);
      tick();
      tick();
      model_complete(t, a, p, par, stop, 1'b0);
      chk_model("rand.frame");
      exp_ovr = 1'b0;
      if (!stop) begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) tick();
      end
      idle($urandom_range(1, 3));
    end

    // Reset in the middle of a frame
    if (!exp_has) begin
      send_frame(3'b011, 4'b1111, 8'h77, even_par(3'b011, 4'b1111, 8'h77), 1'b1, FB + 2);
      tick();
      tick();
      model_complete(3'b011, 4'b1111, 8'h77, even_par(3'b011, 4'b1111, 8'h77), 1'b1, 1'b0);
      chk_model("pre_reset_pkt");
      idle(2);
    end
    send_frame(3'b010, 4'b0110, 8'h99, 1'b0, 1'b1, 7);
    Rst_n = 1'b0;
    #1;
    exp_has = 1'b0;
    exp_t   = '0;
    exp_a   = '0;
    exp_p   = '0;
    exp_b   = 1'b0;
    exp_ovr = 1'b0;
    chk_model("midframe_reset");
    Rx_In = 1'b1;
    tick();
    tick();
    Rst_n = 1'b1;
    for (int i = 0; i < (FB + 4); i++) begin
      tick();
      chk_model("reset_release.quiet");
    end
    send_frame(3'b010, 4'b0011, 8'h3C, even_par(3'b010, 4'b0011, 8'h3C), 1'b1, FB + 2);
    tick();
    tick();
    model_complete(3'b010, 4'b0011, 8'h3C, even_par(3'b010, 4'b0011, 8'h3C), 1'b1, 1'b0);
    chk_model("after_reset_frame");
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
